bsg_clk_gen_osc_slew: RTL and testbench
=======================================

Name: bsg_clk_gen_osc_slew

Overview:
- Synthesizable, cycle-based multi-channel oscillator-control model for the clock generator.
- Holds a staged control word {adg, cdt, fdt} per channel, applies staged words on a trigger, and optionally slews each applied word one LSB at a time.
- Each channel emits a divided square wave whose half-period is (2^W - ctrl) clk_i cycles, the discrete analogue of the ring-oscillator delay law.
- Used for clock-generator emulation in FPGA/sim builds and as the control front end for hardened oscillators.

Parameters:
- num_adgs_p, 1, number of ADG control bits; control width W = 4 + num_adgs_p.
- num_channels_p, 2, number of independent oscillator channels.
- step_cycles_p, 4, clk_i cycles between slew steps (>= 1).

Ports:
- clk_i  in  1  sole clock.
- reset_n_i  in  1  synchronous, active-low reset.
- cfg_v_i  in  1  staged-word write valid.
- cfg_ch_i  in  `BSG_SAFE_CLOG2(num_channels_p)  channel index for the write.
- cfg_data_i  in  W  word {adg, cdt, fdt}, with adg in the MSBs.
- cfg_ready_o  out  1  write accepted when cfg_v_i & cfg_ready_o.
- trigger_i  in  1  apply all staged words.
- ctrl_o  out  num_channels_p*W  currently applied word per channel (channel 0 in the LSBs).
- busy_o  out  num_channels_p  channel is slewing.
- done_o  out  1  one-cycle pulse when an apply completes.
- osc_o  out  num_channels_p  per-channel oscillator output.

Behaviour:
- Reset (reset_n_i=0 at posedge):
  - staged, target, ctrl, slew and period counters all return to 0.
  - osc_o=0, busy_o=0, done_o=0, cfg_ready_o=0 while reset_n_i is low.
  - Reset mid-slew aborts the slew with no done_o pulse.
- Outside reset, cfg_ready_o = ~|busy_o.
- Config write: an accepted write updates staged[cfg_ch_i] at the next edge. A write with cfg_ch_i >= num_channels_p is accepted and discarded.
- Trigger:
  - trigger_i high while ~|busy_o copies staged to target for every channel.
  - trigger_i high while any channel is busy is ignored, with no side effects.
  - Write and trigger in the same cycle: the trigger captures the pre-write staged value; the new value waits for the next trigger.
- Per-channel slew FSM, two states:
  - IDLE->SLEW on an accepted trigger with target != ctrl. The step counter loads 0.
  - In SLEW, the counter increments each cycle. When it reaches step_cycles_p-1, ctrl moves +1 or -1 toward target and the counter resets. The first step therefore lands step_cycles_p cycles after the trigger edge.
  - SLEW->IDLE in the cycle ctrl_o becomes equal to target; busy_o is low from that cycle.
  - Channels with equal target stay IDLE.
- done_o:
  - Pulses exactly one cycle, in the first cycle all channels are IDLE after an accepted trigger.
  - If no channel needed slewing, it pulses in the cycle after the trigger.
- Oscillator:
  - Per-channel counter of W+1 bits; H = 2^W - ctrl, range 1..2^W.
  - When counter >= H-1, osc toggles and the counter clears; otherwise the counter increments.
  - Using >= means a mid-period decrease of H toggles on the next cycle, never wraps.
  - ctrl = 2^W-1 toggles every cycle.

Optional Feature:
- Macro: BSG_CLK_GEN_OSC_SLEW_EN.
- Defined: slewing behaves as above.
- Undefined:
  - An accepted trigger loads ctrl=staged directly at the next edge.
  - busy_o is tied 0 and cfg_ready_o is 1 outside reset.
  - done_o pulses the cycle after the trigger.
  - The step counters are removed.

Test Plan (num_adgs_p=1 so W=5, step_cycles_p=4, macro defined unless stated):
- Release reset with no config -> ctrl_o=0; osc0/osc1 first toggle 32 cycles after release, then every 32 cycles (period 64).
- Write ch0=31, trigger -> ctrl0 steps 0->1 at +4 cycles and reaches 31 at +124; busy0 high throughout; done_o single pulse at +125; osc0 then toggles every cycle; ch1 stays 0.
- During the slew above, drive trigger_i and cfg_v_i -> cfg_ready_o=0, trigger ignored, staged unchanged, ctrl0 path unchanged.
- Staged ch1=10 (already applied), same cycle write ch1=20 and trigger -> ch1 target=10, no busy, done_o pulses next cycle; a second trigger slews ch1 to 20 in 40 cycles.
- Reset asserted at +60 of a 0->31 slew -> next edge ctrl0=0, busy0=0, osc0=0, no done_o pulse.
- Macro undefined: write ch0=16, trigger -> ctrl0=16 next edge, busy_o never set, done_o one cycle later, osc0 half-period 16.

Source files
------------

// File: rtl/bsg_clk_gen_osc_slew.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : bsg_clk_gen_osc_slew                                           |
// | Brief   : Cycle-based multi-channel oscillator-control model. Holds a    |
// |           staged {adg, cdt, fdt} word per channel, applies all staged    |
// |           words on a trigger and drives a divided square wave whose      |
// |           half-period is (2^W - ctrl) clk_i cycles.                      |
// | Option  : BSG_CLK_GEN_OSC_SLEW_EN - when defined, applied words walk     |
// |           toward their target one LSB every step_cycles_p cycles;        |
// |           otherwise a trigger loads the staged words directly.           |
// | Rev     : 1.0 - initial release                                          |
// +------------------------------------------------------------------------+

`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif

module bsg_clk_gen_osc_slew #(
    parameter int num_adgs_p     = 1,
    parameter int num_channels_p = 2,
    parameter int step_cycles_p  = 4
) (
    input  logic                                          clk_i,
    input  logic                                          reset_n_i,
    input  logic                                          cfg_v_i,
    input  logic [`BSG_SAFE_CLOG2(num_channels_p)-1:0]    cfg_ch_i,
    input  logic [4+num_adgs_p-1:0]                       cfg_data_i,
    output logic                                          cfg_ready_o,
    input  logic                                          trigger_i,
    output logic [num_channels_p*(4+num_adgs_p)-1:0]      ctrl_o,
    output logic [num_channels_p-1:0]                     busy_o,
    output logic                                          done_o,
    output logic [num_channels_p-1:0]                     osc_o
);

    localparam int c_w     = 4 + num_adgs_p;
    localparam int c_ch_w  = `BSG_SAFE_CLOG2(num_channels_p);
    localparam int c_cnt_w = c_w + 1;
    // 2^W: half-period for ctrl = 0
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(1) << c_w;

    // A zero step interval would make the slew rate meaningless
    if (step_cycles_p < 1) begin : g_step_check
        $error("step_cycles_p must be >= 1");
    end

    logic [c_w-1:0]            r_staged [num_channels_p];
    logic [c_w-1:0]            r_ctrl   [num_channels_p];
    logic [num_channels_p-1:0] w_busy;
    logic [num_channels_p-1:0] w_wr_en;
    logic                      w_trig_acc;
    logic                      w_all_idle;
    logic                      r_pending;
    logic                      r_done;

    // Writes and triggers are only taken while no channel is moving
    assign cfg_ready_o = reset_n_i & ~|w_busy;
    assign w_trig_acc  = trigger_i & cfg_ready_o;
    assign w_all_idle  = ~|w_busy;

    // Channel decode; an index with no matching channel is simply dropped
    always_comb begin
        for (int i = 0; i < num_channels_p; i++) begin
            w_wr_en[i] = cfg_v_i & cfg_ready_o & (cfg_ch_i == c_ch_w'(i));
        end
    end

    // Staged words, written one channel at a time by the config port
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < num_channels_p; i++) begin
                r_staged[i] <= '0;
            end
        end else begin
            for (int i = 0; i < num_channels_p; i++) begin
                if (w_wr_en[i]) begin
                    r_staged[i] <= cfg_data_i;
                end
            end
        end
    end

`ifdef BSG_CLK_GEN_OSC_SLEW_EN
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SLEW = 1'b1
    } slew_state_e;

    localparam int c_step_w = `BSG_SAFE_CLOG2(step_cycles_p);
    localparam logic [c_step_w-1:0] c_step_last = c_step_w'(step_cycles_p - 1);

    slew_state_e         r_state     [num_channels_p];
    slew_state_e         w_state_nxt [num_channels_p];
    logic [c_step_w-1:0] r_step_cnt  [num_channels_p];
    logic [c_step_w-1:0] w_step_nxt  [num_channels_p];
    logic [c_w-1:0]      r_target    [num_channels_p];
    logic [c_w-1:0]      w_ctrl_nxt  [num_channels_p];
    logic [c_w-1:0]      w_ctrl_step [num_channels_p];

    // A channel is busy for as long as its slew FSM is active
    always_comb begin
        for (int i = 0; i < num_channels_p; i++) begin
            w_busy[i] = (r_state[i] == ST_SLEW);
        end
    end

    // Slew state, step counter, applied word and target per channel
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < num_channels_p; i++) begin
                r_state[i]    <= ST_IDLE;
                r_step_cnt[i] <= '0;
                r_ctrl[i]     <= '0;
                r_target[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < num_channels_p; i++) begin
                r_state[i]    <= w_state_nxt[i];
                r_step_cnt[i] <= w_step_nxt[i];
                r_ctrl[i]     <= w_ctrl_nxt[i];
                if (w_trig_acc) begin
                    r_target[i] <= r_staged[i];
                end
            end
        end
    end

    // Next state: start on an accepted trigger, move one LSB per step interval
    always_comb begin
        for (int i = 0; i < num_channels_p; i++) begin
            w_state_nxt[i] = r_state[i];
            w_step_nxt[i]  = r_step_cnt[i];
            w_ctrl_nxt[i]  = r_ctrl[i];
            w_ctrl_step[i] = (r_target[i] > r_ctrl[i]) ? (r_ctrl[i] + 1'b1)
                                                       : (r_ctrl[i] - 1'b1);
            case (r_state[i])
                ST_IDLE: begin
                    // Compare against staged: target is loaded at this same edge
                    if (w_trig_acc && (r_staged[i] != r_ctrl[i])) begin
                        w_state_nxt[i] = ST_SLEW;
                        w_step_nxt[i]  = '0;
                    end
                end
                ST_SLEW: begin
                    if (r_step_cnt[i] == c_step_last) begin
                        w_step_nxt[i] = '0;
                        w_ctrl_nxt[i] = w_ctrl_step[i];
                        // Leave SLEW in the very cycle ctrl lands on target
                        if (w_ctrl_step[i] == r_target[i]) begin
                            w_state_nxt[i] = ST_IDLE;
                        end
                    end else begin
                        w_step_nxt[i] = r_step_cnt[i] + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt[i] = ST_IDLE;
                end
            endcase
        end
    end
`else
    // Without slewing no channel is ever in motion
    assign w_busy = '0;

    // Applied words jump straight to the staged values on a trigger
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < num_channels_p; i++) begin
                r_ctrl[i] <= '0;
            end
        end else if (w_trig_acc) begin
            for (int i = 0; i < num_channels_p; i++) begin
                r_ctrl[i] <= r_staged[i];
            end
        end
    end
`endif

    // Apply-complete tracking: pulse once the first cycle all channels idle
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_pending <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= r_pending & w_all_idle;
            if (w_trig_acc) begin
                r_pending <= 1'b1;
            end else if (r_pending && w_all_idle) begin
                r_pending <= 1'b0;
            end
        end
    end

    logic [c_cnt_w-1:0]        r_osc_cnt [num_channels_p];
    logic [c_cnt_w-1:0]        w_half    [num_channels_p];
    logic [num_channels_p-1:0] w_osc_wrap;
    logic [num_channels_p-1:0] r_osc;

    // Half-period H = 2^W - ctrl; '>=' lets a shrinking H toggle immediately
    always_comb begin
        for (int i = 0; i < num_channels_p; i++) begin
            w_half[i]     = c_full - {1'b0, r_ctrl[i]};
            w_osc_wrap[i] = (r_osc_cnt[i] >= (w_half[i] - c_cnt_w'(1)));
        end
    end

    // Oscillator counters and outputs
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < num_channels_p; i++) begin
                r_osc_cnt[i] <= '0;
            end
            r_osc <= '0;
        end else begin
            for (int i = 0; i < num_channels_p; i++) begin
                if (w_osc_wrap[i]) begin
                    r_osc_cnt[i] <= '0;
                    r_osc[i]     <= ~r_osc[i];
                end else begin
                    r_osc_cnt[i] <= r_osc_cnt[i] + c_cnt_w'(1);
                end
            end
        end
    end

    // Channel 0 occupies the LSBs of the packed control bus
    for (genvar g = 0; g < num_channels_p; g++) begin : g_ctrl_pack
        assign ctrl_o[g*c_w +: c_w] = r_ctrl[g];
    end

    // Status outputs read as zero for as long as reset is held
    assign busy_o = w_busy & {num_channels_p{reset_n_i}};
    assign osc_o  = r_osc  & {num_channels_p{reset_n_i}};
    assign done_o = r_done & reset_n_i;

endmodule

`default_nettype wire

// File: tb/tb_bsg_clk_gen_osc_slew.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_bsg_clk_gen_osc_slew                                        |
// | Brief   : Directed self-checking bench for bsg_clk_gen_osc_slew with     |
// |           W = 5, two channels and a 4-cycle slew step. Covers both       |
// |           builds of BSG_CLK_GEN_OSC_SLEW_EN.                             |
// | Rev     : 1.0 - initial release                                          |
// +------------------------------------------------------------------------+
module tb_bsg_clk_gen_osc_slew;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cfg_v;
    logic [0:0] cfg_ch;
    logic [4:0] cfg_data;
    logic       cfg_ready;
    logic       trigger;
    logic [9:0] ctrl;
    logic [1:0] busy;
    logic       done;
    logic [1:0] osc;
    logic [4:0] ctrl0;
    logic [4:0] ctrl1;

    assign ctrl0 = ctrl[4:0];
    assign ctrl1 = ctrl[9:5];

    always #5 clk = ~clk;

    bsg_clk_gen_osc_slew #(
        .num_adgs_p     (1),
        .num_channels_p (2),
        .step_cycles_p  (4)
    ) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .cfg_v_i     (cfg_v),
        .cfg_ch_i    (cfg_ch),
        .cfg_data_i  (cfg_data),
        .cfg_ready_o (cfg_ready),
        .trigger_i   (trigger),
        .ctrl_o      (ctrl),
        .busy_o      (busy),
        .done_o      (done),
        .osc_o       (osc)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic expect_val(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_errors++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] val);
        expect_val(tag, val);
        check(obs);
    endtask

    task automatic write_cfg(input int ch, input int d);
        cfg_v    = 1'b1;
        cfg_ch   = 1'(ch);
        cfg_data = 5'(d);
        tick();
        cfg_v    = 1'b0;
    endtask

    task automatic pulse_trig();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
    endtask

    // Cycles between two consecutive toggles of one osc channel, bounded
    task automatic measure_half(input int ch, input int max, output int cycles);
        logic prev;
        int   n;
        prev = osc[ch];
        n    = 0;
        while (osc[ch] === prev && n < max) begin tick(); n++; end
        prev = osc[ch];
        n    = 0;
        while (osc[ch] === prev && n < max) begin tick(); n++; end
        cycles = n;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int half;
        reset_n  = 1'b0;
        cfg_v    = 1'b0;
        cfg_ch   = '0;
        cfg_data = '0;
        trigger  = 1'b0;

        // Reset state
        ticks(2);
        chk("rst_ready", cfg_ready, 0);
        chk("rst_busy",  busy,      0);
        chk("rst_done",  done,      0);
        chk("rst_osc",   osc,       0);
        chk("rst_ctrl",  ctrl,      0);

        // Release with no config: half-period 32 on both channels
        reset_n = 1'b1;
        tick();
        chk("rel_ready", cfg_ready, 1);
        ticks(30);
        chk("osc_e31", osc, 0);
        tick();
        chk("osc_e32", osc, 2'b11);
        ticks(31);
        chk("osc_e63", osc, 2'b11);
        tick();
        chk("osc_e64", osc, 0);

`ifdef BSG_CLK_GEN_OSC_SLEW_EN
        // Slew ch0 0 -> 31
        write_cfg(0, 31);
        expect_val("a_busy_t0",  1);
        expect_val("a_ready_t0", 0);
        expect_val("a_ctrl0_t0", 0);
        pulse_trig();
        check(busy);
        check(cfg_ready);
        check(ctrl0);
        ticks(3);
        chk("a_ctrl0_t3", ctrl0, 0);
        tick();
        chk("a_ctrl0_t4", ctrl0, 1);

        // Write and trigger while busy: both must be ignored
        trigger  = 1'b1;
        cfg_v    = 1'b1;
        cfg_ch   = 1'b0;
        cfg_data = 5'd5;
        tick();
        trigger  = 1'b0;
        cfg_v    = 1'b0;
        chk("a_ready_busy", cfg_ready, 0);
        chk("a_busy_t5",    busy,      1);
        chk("a_ctrl0_t5",   ctrl0,     1);
        ticks(3);
        chk("a_ctrl0_t8",   ctrl0,     2);
        ticks(115);
        chk("a_ctrl0_t123", ctrl0,     30);
        chk("a_busy_t123",  busy,      1);
        tick();
        chk("a_ctrl0_t124", ctrl0,     31);
        chk("a_busy_t124",  busy,      0);
        chk("a_done_t124",  done,      0);
        chk("a_ready_t124", cfg_ready, 1);
        tick();
        chk("a_done_t125",  done,      1);
        tick();
        chk("a_done_t126",  done,      0);
        chk("a_ctrl1",      ctrl1,     0);
        measure_half(0, 100, half);
        chk("a_osc0_half",  half,      1);

        // Staged ch0 must still be 31: re-trigger needs no slew
        pulse_trig();
        chk("a_retrig_busy",  busy,  0);
        chk("a_retrig_ctrl0", ctrl0, 31);
        tick();
        chk("a_retrig_done",  done,  1);

        // Apply ch1 = 10
        write_cfg(1, 10);
        pulse_trig();
        chk("b_busy_t0",   busy,  2);
        ticks(39);
        chk("b_ctrl1_t39", ctrl1, 9);
        tick();
        chk("b_ctrl1_t40", ctrl1, 10);
        chk("b_busy_t40",  busy,  0);
        tick();
        chk("b_done_t41",  done,  1);

        // Same-cycle write 20 and trigger: trigger sees staged 10
        cfg_v    = 1'b1;
        cfg_ch   = 1'b1;
        cfg_data = 5'd20;
        trigger  = 1'b1;
        tick();
        cfg_v    = 1'b0;
        trigger  = 1'b0;
        chk("b_same_busy",  busy,  0);
        chk("b_same_ctrl1", ctrl1, 10);
        tick();
        chk("b_same_done",  done,  1);
        pulse_trig();
        ticks(39);
        chk("b2_ctrl1_t39", ctrl1, 19);
        chk("b2_busy_t39",  busy,  2);
        tick();
        chk("b2_ctrl1_t40", ctrl1, 20);
        chk("b2_busy_t40",  busy,  0);
        chk("b2_ctrl0",     ctrl0, 31);

        // Downward slew 20 -> 18
        write_cfg(1, 18);
        pulse_trig();
        ticks(4);
        chk("dn_ctrl1_t4", ctrl1, 19);
        chk("dn_busy_t4",  busy,  2);
        ticks(4);
        chk("dn_ctrl1_t8", ctrl1, 18);
        chk("dn_busy_t8",  busy,  0);

        // Reset in the middle of a slew
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        write_cfg(0, 31);
        pulse_trig();
        ticks(59);
        chk("c_ctrl0_t59", ctrl0, 14);
        chk("c_busy_t59",  busy,  1);
        reset_n = 1'b0;
        tick();
        chk("c_ctrl0_rst", ctrl0,     0);
        chk("c_busy_rst",  busy,      0);
        chk("c_osc0_rst",  osc[0],    0);
        chk("c_done_rst",  done,      0);
        chk("c_ready_rst", cfg_ready, 0);
        reset_n = 1'b1;
        tick();
        chk("c_done_1", done, 0);
        tick();
        chk("c_done_2",  done,  0);
        chk("c_busy_2",  busy,  0);
        chk("c_ctrl0_2", ctrl0, 0);
`else
        // Direct apply ch0 = 16
        write_cfg(0, 16);
        expect_val("d_ctrl0_t0", 16);
        pulse_trig();
        check(ctrl0);
        chk("d_busy_t0",  busy,      0);
        chk("d_done_t0",  done,      0);
        chk("d_ready_t0", cfg_ready, 1);
        tick();
        chk("d_done_t1",  done,      1);
        tick();
        chk("d_done_t2",  done,      0);
        measure_half(0, 100, half);
        chk("d_osc0_half", half,  16);
        chk("d_ctrl1",     ctrl1, 0);

        // Same-cycle write and trigger
        write_cfg(1, 10);
        pulse_trig();
        chk("d_ctrl1_10", ctrl1, 10);
        cfg_v    = 1'b1;
        cfg_ch   = 1'b1;
        cfg_data = 5'd20;
        trigger  = 1'b1;
        tick();
        cfg_v    = 1'b0;
        trigger  = 1'b0;
        chk("d_same_ctrl1", ctrl1, 10);
        tick();
        chk("d_same_done",  done,  1);
        pulse_trig();
        chk("d_ctrl1_20",   ctrl1, 20);
        chk("d_busy_20",    busy,  0);
        chk("d_ctrl0_kept", ctrl0, 16);

        // Reset clears applied words
        reset_n = 1'b0;
        tick();
        chk("d_rst_ctrl",  ctrl,      0);
        chk("d_rst_ready", cfg_ready, 0);
        chk("d_rst_osc",   osc,       0);
        reset_n = 1'b1;
        tick();
        chk("d_rel_ready", cfg_ready, 1);
`endif

        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
